// File: rtl/rv32i_pkg.sv
// Shared RV32I types and constants for the fetch front end, decode and benches.
package rv32i_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] word_t;

   typedef struct packed {
      word_t instr;
      word_t pc;
   } fetch_entry_t;

   localparam word_t INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/rv32i_fetch_unit_if.sv
// Fetch unit bus bundle: ROM read port, redirect request and decode handshake.
interface rv32i_fetch_unit_if;
   import rv32i_pkg::*;

   logic  rom_en;
   word_t rom_addr;
   word_t rom_data;
   logic  redirect_valid;
   word_t redirect_pc;
   logic  out_valid;
   word_t out_instr;
   word_t out_pc;
   logic  out_ready;

   modport master (
      output rom_en, rom_addr, out_valid, out_instr, out_pc,
      input  rom_data, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  rom_en, rom_addr, out_valid, out_instr, out_pc,
      output rom_data, redirect_valid, redirect_pc, out_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries; flush wins over push and pop.
module fetch_fifo
   import rv32i_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clock,
   input  logic          async_reset,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  fetch_entry_t  push_data,
   output fetch_entry_t  head,
   output logic [CW-1:0] count
);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && (count != CW'(DEPTH));
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock or negedge async_reset) begin
      if (!async_reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rv32i_fetch_unit.sv
// RV32I fetch front end: PC register, one-deep in-flight ROM tracking and
// credit-based issue into the prefetch FIFO feeding decode.
module rv32i_fetch_unit
   import rv32i_pkg::*;
#(
   parameter word_t RESET_PC = 32'h0000_0000,
   parameter int    DEPTH    = 4
) (
   input logic                clock,
   input logic                async_reset,
   rv32i_fetch_unit_if.master bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   word_t         fetch_pc;
   word_t         inflight_pc;
   logic          inflight;
   logic          issue;
   logic          push;
   logic          pop;
   logic          flush;
   logic [CW-1:0] count;
   logic [CW:0]   used;
   fetch_entry_t  head;
   fetch_entry_t  push_data;

   // Credit counts the in-flight word as occupied; pre-pop count keeps
   // out_ready off the rom_en path.
   assign used  = {1'b0, count} + (CW+1)'(inflight);
   assign flush = bus.redirect_valid;
   assign issue = async_reset && !bus.redirect_valid && (used < (CW+1)'(DEPTH));
   assign push  = inflight && !flush;
   assign pop   = bus.out_valid && bus.out_ready;

   assign push_data.instr = bus.rom_data;
   assign push_data.pc    = inflight_pc;

   assign bus.rom_en    = issue;
   assign bus.rom_addr  = fetch_pc;
   assign bus.out_valid = (count != '0);
   assign bus.out_instr = head.instr;
   assign bus.out_pc    = head.pc;

   always_ff @(posedge clock or negedge async_reset) begin
      if (!async_reset) begin
         fetch_pc    <= RESET_PC;
         inflight_pc <= RESET_PC;
         inflight    <= 1'b0;
      end else if (flush) begin
         fetch_pc <= bus.redirect_pc & ~word_t'(3);
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + word_t'(4);
         end
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock       (clock),
      .async_reset (async_reset),
      .flush       (flush),
      .push        (push),
      .pop         (pop),
      .push_data   (push_data),
      .head        (head),
      .count       (count)
   );

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit; ROM model returns word = address.
module tb_rv32i_fetch_unit;
   import rv32i_pkg::*;

   logic clock;
   logic async_reset;
   int   n_checks;
   int   n_pass;

   rv32i_fetch_unit_if bus ();

   rv32i_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
      .clock       (clock),
      .async_reset (async_reset),
      .bus         (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) if (bus.rom_en) bus.rom_data <= bus.rom_addr;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reset asserted and released on falling edges, i.e. between rising edges.
   task automatic apply_reset();
      @(negedge clock);
      async_reset = 1'b0;
      bus.redirect_valid = 1'b0;
      @(negedge clock);
      async_reset = 1'b1;
      #1;
   endtask

   initial begin
      logic [31:0] drain_pc [5];
      logic [31:0] wrap_pc [4];
      drain_pc = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
      wrap_pc  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
      n_checks = 0;
      n_pass   = 0;

      // Reset release
      async_reset        = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.out_ready      = 1'b1;
      #2;
      check_val("rst_rom_en",    32'(bus.rom_en),    32'd0);
      check_val("rst_rom_addr",  bus.rom_addr,       32'h0);
      check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_val("rst_out_instr", bus.out_instr,      32'h0);
      check_val("rst_out_pc",    bus.out_pc,         32'h0);
      #11;
      async_reset = 1'b1;
      #1;
      check_val("rel_rom_en",   32'(bus.rom_en), 32'd1);
      check_val("rel_rom_addr", bus.rom_addr,    32'h0);
      tick();
      check_val("e1_rom_addr",  bus.rom_addr,       32'h4);
      check_val("e1_out_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check_val("e2_out_valid", 32'(bus.out_valid), 32'd1);
      check_val("e2_out_pc",    bus.out_pc,         32'h0);
      check_val("e2_out_instr", bus.out_instr,      32'h0);
      check_val("e2_rom_addr",  bus.rom_addr,       32'h8);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_val("stream_valid", 32'(bus.out_valid), 32'd1);
         check_val("stream_pc",    bus.out_pc,         32'(4 * i));
         check_val("stream_instr", bus.out_instr,      32'(4 * i));
      end

      // Backpressure
      bus.out_ready = 1'b0;
      apply_reset();
      repeat (3) tick();
      tick();
      check_val("bp_rom_en_stop", 32'(bus.rom_en), 32'd0);
      check_val("bp_rom_addr",    bus.rom_addr,    32'h10);
      tick();
      check_val("bp_valid", 32'(bus.out_valid), 32'd1);
      check_val("bp_head",  bus.out_pc,         32'h0);
      tick();
      tick();
      check_val("bp_hold_head",   bus.out_pc,      32'h0);
      check_val("bp_hold_instr",  bus.out_instr,   32'h0);
      check_val("bp_hold_rom_en", 32'(bus.rom_en), 32'd0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_val("drain_valid", 32'(bus.out_valid), 32'd1);
         check_val("drain_pc",    bus.out_pc,         drain_pc[i]);
      end

      // Reset mid-operation, FIFO at 3 entries
      bus.out_ready = 1'b0;
      apply_reset();
      repeat (5) tick();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check_val("mr_pre_rom_en", 32'(bus.rom_en),    32'd1);
      check_val("mr_pre_valid",  32'(bus.out_valid), 32'd1);
      check_val("mr_pre_pc",     bus.out_pc,         32'h4);
      #3;
      async_reset = 1'b0;
      #1;
      check_val("mr_rom_en",   32'(bus.rom_en),    32'd0);
      check_val("mr_valid",    32'(bus.out_valid), 32'd0);
      check_val("mr_rom_addr", bus.rom_addr,       32'h0);
      check_val("mr_out_pc",   bus.out_pc,         32'h0);
      @(negedge clock);
      async_reset   = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      check_val("mr_rel_addr", bus.rom_addr, 32'h0);
      tick();
      tick();
      check_val("mr_rel_valid", 32'(bus.out_valid), 32'd1);
      check_val("mr_rel_pc",    bus.out_pc,         32'h0);

      // Redirect mid-stream, coinciding with pop and ROM return
      apply_reset();
      repeat (10) tick();
      check_val("rd_pre_head", bus.out_pc,   32'h20);
      check_val("rd_pre_addr", bus.rom_addr, 32'h28);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h103;
      #1;
      check_val("rd_rom_en", 32'(bus.rom_en), 32'd0);
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      check_val("rd_flush_valid", 32'(bus.out_valid), 32'd0);
      check_val("rd_rom_en_next", 32'(bus.rom_en),    32'd1);
      check_val("rd_rom_addr",    bus.rom_addr,       32'h100);
      tick();
      check_val("rd_gap_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check_val("rd_new_valid", 32'(bus.out_valid), 32'd1);
      check_val("rd_new_pc",    bus.out_pc,         32'h100);
      check_val("rd_new_instr", bus.out_instr,      32'h100);
      tick();
      check_val("rd_next_pc", bus.out_pc, 32'h104);

      // Back-to-back redirects: last wins
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h300;
      #1;
      check_val("b2b_rom_en_a", 32'(bus.rom_en), 32'd0);
      tick();
      bus.redirect_pc = 32'h400;
      #1;
      check_val("b2b_rom_en_b", 32'(bus.rom_en),    32'd0);
      check_val("b2b_valid",    32'(bus.out_valid), 32'd0);
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      check_val("b2b_rom_addr", bus.rom_addr, 32'h400);
      tick();
      tick();
      check_val("b2b_pc", bus.out_pc, 32'h400);

      // Wrap-around, low redirect bits ignored
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFA;
      tick();
      bus.redirect_valid = 1'b0;
      tick();
      check_val("wrap_gap_valid", 32'(bus.out_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_val("wrap_valid", 32'(bus.out_valid), 32'd1);
         check_val("wrap_pc",    bus.out_pc,         wrap_pc[i]);
         check_val("wrap_instr", bus.out_instr,      wrap_pc[i]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rv32i_fetch_unit.md
Name: rv32i_fetch_unit

Overview:
- Instruction fetch front end that sits directly upstream of the RV32I core's decode stage.
- Drives a synchronous instruction ROM (1-cycle read latency) from a PC register.
- Buffers the returned words with their PCs in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects from the core by flushing all buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset release.
- DEPTH, 4, prefetch FIFO entries. Power of two, minimum 2. Full throughput requires DEPTH>=3.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- async_reset  in  1  asynchronous, active-low reset (0 = in reset).
- rom_en  out  1  ROM read enable for this cycle.
- rom_addr  out  32  byte address of the ROM read; bits [1:0] are always 0.
- rom_data  in  32  ROM read data, valid the cycle after the rom_en edge.
- redirect_valid  in  1  core requests a fetch restart.
- redirect_pc  in  32  restart address; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  head instruction available.
- out_instr  out  32  head instruction word.
- out_pc  out  32  PC of the head instruction.
- out_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Reset (async_reset=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; in-flight flag cleared.
  - rom_en=0, rom_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
  - Reset asserted mid-operation discards everything immediately, without waiting for a clock edge.
- Issue (combinational):
  - rom_en = reset released AND !redirect_valid AND (fifo_count + inflight) < DEPTH.
  - rom_addr = fetch_pc.
  - On an edge with rom_en=1: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
  - PC arithmetic is modulo 2^32: 0xFFFF_FFFC + 4 = 0x0000_0000, with no error flag.
- Return:
  - On the edge after an issue, if inflight=1, {rom_data, inflight_pc} is pushed into the FIFO.
  - inflight clears unless a new issue occurs on the same edge.
- Latency:
  - Issue visible before edge E1.
  - ROM data valid after E1.
  - FIFO write at E2; out_valid=1 after E2.
  - Total 2 edges from issue to presentation.
- Output handshake:
  - out_valid = fifo non-empty; out_instr/out_pc are the FIFO head.
  - Pop on any edge where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, the head is held stable.
  - No combinational path from out_ready to rom_en; credit uses the pre-pop count.
- Simultaneous push and pop: both happen, and the count is unchanged. The full check uses the credit rule, so a push never overflows.
- Redirect (redirect_valid=1 at an edge):
  - FIFO flushed (count=0); inflight cleared. The ROM word returning that cycle is dropped.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - rom_en=0 in the redirect cycle; the first fetch of the new PC issues the following cycle.
  - Redirect has priority over a same-cycle pop: the head is discarded and not counted as accepted.
  - Redirect has priority over a same-cycle push: the push is suppressed.
  - Back-to-back redirects: the last one wins and no fetch issues until redirect_valid drops.
- Steady state, out_ready=1, DEPTH>=3: one instruction per cycle, with PCs consecutive by +4.
- Empty FIFO with out_ready=1: out_valid=0. No bypass of the FIFO.

Decomposition:
- Package rv32i_pkg holds:
  - XLEN=32;
  - typedef word_t (logic [XLEN-1:0]);
  - typedef fetch_entry_t struct {word_t instr; word_t pc;};
  - INSTR_NOP=32'h0000_0013 (for benches and the core).
- Sub-module fetch_fifo:
  - synchronous FIFO of fetch_entry_t, DEPTH entries, with push/pop/flush and count output;
  - same clock and async_reset;
  - flush has priority over push and pop.
- The top holds the PC register, the in-flight tracking and the credit logic.

Test Plan:
- Reset release:
  - Stimulus: async_reset low for 13 ns, then high; ROM holds word = address; out_ready=1.
  - Response: rom_addr sequence 0,4,8,...; first out_valid two edges after release with out_pc=0, out_instr=0; then one entry per cycle.
- Backpressure:
  - Stimulus: out_ready=0 after release.
  - Response: rom_en stops once count+inflight=4; FIFO holds PCs 0,4,8,C; head stable at PC 0. Raising out_ready drains 0,4,8,C,10 in order, with no gaps after the first cycle.
- Redirect mid-stream:
  - Stimulus: redirect_pc=0x103 pulsed while words for PCs 0x20/0x24 are buffered/in flight.
  - Response: those words are never presented; rom_en=0 in the redirect cycle; next rom_addr=0x100; next out_pc=0x100.
- Redirect coinciding with pop and with ROM return:
  - Stimulus: out_valid && out_ready && redirect_valid on the same edge.
  - Response: out_valid=0 next cycle; the dropped word never reappears.
- Wrap-around:
  - Stimulus: redirect to 0xFFFF_FFF8.
  - Response: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Reset mid-operation:
  - Stimulus: async_reset driven low between clock edges with FIFO at 3 entries.
  - Response: out_valid and rom_en drop immediately, before the next edge; after release, fetch restarts at RESET_PC.
